// File: rtl/prince_sr_rcadd.sv
// PRINCE round stage: registers ShiftRows / round-constant / key addition with a 1..10 round counter
// behind a single-entry valid/ready output register. Define PRINCE_RC_ROM_EN to use the internal RC ROM instead of rc_in.
module prince_sr_rcadd #(
  parameter int RC_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic [63:0]         data_in,
  input  logic [63:0]         key_in,
`ifndef PRINCE_RC_ROM_EN
  input  logic [RC_WIDTH-1:0] rc_in,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         data_out,
  output logic [3:0]          round_out,
  output logic                out_last
);

  // Element 15 is bits [63:60], i.e. state nibble 0.
  typedef logic [15:0][3:0] state_t;

  localparam logic [3:0] SR_IDX [16] = '{
    4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3,
    4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6, 4'd11
  };
  localparam logic [3:0] SRI_IDX [16] = '{
    4'd0, 4'd13, 4'd10, 4'd7, 4'd4, 4'd1, 4'd14, 4'd11,
    4'd8, 4'd5, 4'd2, 4'd15, 4'd12, 4'd9, 4'd6, 4'd3
  };

  localparam logic [3:0] ROUND_FIRST = 4'd1;
  localparam logic [3:0] ROUND_LAST  = 4'd10;
  localparam logic [3:0] ROUND_FWD_MAX = 4'd5;

  function automatic logic [63:0] shift_rows(input logic [63:0] s, input logic inv);
    state_t src;
    state_t dst;
    logic [3:0] idx;
    src = state_t'(s);
    dst = '0;
    for (int i = 0; i < 16; i++) begin
      idx = inv ? SRI_IDX[i] : SR_IDX[i];
      dst[4'(15 - i)] = src[4'd15 - idx];
    end
    return 64'(dst);
  endfunction

`ifdef PRINCE_RC_ROM_EN
  function automatic logic [63:0] rc_rom(input logic [3:0] r);
    logic [63:0] v;
    case (r)
      4'd1:    v = 64'h13198a2e03707344;
      4'd2:    v = 64'ha4093822299f31d0;
      4'd3:    v = 64'h082efa98ec4e6c89;
      4'd4:    v = 64'h452821e638d01377;
      4'd5:    v = 64'hbe5466cf34e90c6c;
      4'd6:    v = 64'h7ef84f78fd955cb1;
      4'd7:    v = 64'h85840851f1ac43aa;
      4'd8:    v = 64'hc882d32f25323c54;
      4'd9:    v = 64'h64a51195e0e3610d;
      4'd10:   v = 64'hd3b5a399ca0c2399;
      default: v = '0;
    endcase
    return v;
  endfunction
`endif

  logic [3:0]  r_q;
  logic [3:0]  r_use;
  logic [3:0]  r_next;
  logic [63:0] rc;
  logic [63:0] result;
  logic        accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign r_use    = in_first ? ROUND_FIRST : r_q;
  assign r_next   = (r_use == ROUND_LAST) ? ROUND_FIRST : r_use + 4'd1;

`ifdef PRINCE_RC_ROM_EN
  assign rc = rc_rom(r_use);
`else
  assign rc = 64'(rc_in);
`endif

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    result = '0;
    if (r_use <= ROUND_FWD_MAX) result = shift_rows(data_in, 1'b0) ^ rc ^ key_in;
    else                        result = shift_rows(data_in ^ rc ^ key_in, 1'b1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= ROUND_FIRST;
      out_valid <= 1'b0;
      data_out  <= '0;
      round_out <= ROUND_FIRST;
      out_last  <= 1'b0;
    end else if (accept) begin
      r_q       <= r_next;
      out_valid <= 1'b1;
      data_out  <= result;
      round_out <= r_use;
      out_last  <= (r_use == ROUND_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prince_sr_rcadd.sv
// Self-checking bench for prince_sr_rcadd: a nibble-level reference model checked every cycle,
// plus literal vectors that pin the model. Honours PRINCE_RC_ROM_EN the same way as the design.
module tb_prince_sr_rcadd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_first;
  logic [63:0] data_in, key_in, rc_in;
  logic        out_valid, out_ready, out_last;
  logic [63:0] data_out;
  logic [3:0]  round_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prince_sr_rcadd #(.RC_WIDTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .data_in  (data_in),
    .key_in   (key_in),
`ifndef PRINCE_RC_ROM_EN
    .rc_in    (rc_in),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .round_out(round_out),
    .out_last (out_last)
  );

  localparam logic [63:0] RC_TAB [1:10] = '{
    64'h13198a2e03707344, 64'ha4093822299f31d0, 64'h082efa98ec4e6c89,
    64'h452821e638d01377, 64'hbe5466cf34e90c6c, 64'h7ef84f78fd955cb1,
    64'h85840851f1ac43aa, 64'hc882d32f25323c54, 64'h64a51195e0e3610d,
    64'hd3b5a399ca0c2399
  };
  localparam int SR_T  [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
  localparam int SRI_T [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Output nibble i takes input nibble tbl[i]; nibble 0 is the most significant.
  function automatic logic [63:0] perm(input logic [63:0] v, input bit inv);
    logic [63:0] o;
    int src;
    o = 64'h0;
    for (int i = 0; i < 16; i++) begin
      src = inv ? SRI_T[i] : SR_T[i];
      o = (o << 4) | ((v >> (4 * (15 - src))) & 64'hf);
    end
    return o;
  endfunction

  // Reference model
  int          m_r, m_ru, m_round;
  bit          m_valid, m_last;
  logic [63:0] m_data, m_rc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r = 1; m_valid = 0; m_data = 64'h0; m_round = 1; m_last = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_ru = in_first ? 1 : m_r;
`ifdef PRINCE_RC_ROM_EN
      m_rc = RC_TAB[m_ru];
`else
      m_rc = rc_in;
`endif
      if (m_ru <= 5) m_data = perm(data_in, 0) ^ m_rc ^ key_in;
      else           m_data = perm(data_in ^ m_rc ^ key_in, 1);
      m_round = m_ru;
      m_last  = (m_ru == 10);
      m_valid = 1;
      m_r     = (m_ru % 10) + 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("cyc_out_valid", 64'(out_valid), 64'(m_valid));
      check("cyc_in_ready",  64'(in_ready),  64'(!m_valid || out_ready));
      check("cyc_data_out",  data_out,       m_data);
      check("cyc_round_out", 64'(round_out), 64'(m_round));
      check("cyc_out_last",  64'(out_last),  64'(m_last));
    end
  end

  task automatic beat(input bit first, input logic [63:0] d, input logic [63:0] k,
                      input logic [63:0] rc);
    in_valid = 1'b1; in_first = first; data_in = d; key_in = k; rc_in = rc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0;
    data_in = '0; key_in = '0; rc_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_data_out",  data_out,       64'h0);
    check("rst_round_out", 64'(round_out), 64'h1);
    check("rst_out_last",  64'(out_last),  64'h0);
    check("rst_in_ready",  64'(in_ready),  64'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Forward SR
    beat(1'b1, 64'h0123456789abcdef, RC_TAB[1], RC_TAB[1]);
    check("fwd_data",  data_out,       64'h05af49e38d27c16b);
    check("fwd_round", 64'(round_out), 64'h1);
    check("fwd_valid", 64'(out_valid), 64'h1);

    // Backward SR inverse at round 6
    for (int r = 2; r <= 5; r++) beat(1'b0, 64'h0, 64'h0, RC_TAB[r]);
    beat(1'b0, 64'h0123456789abcdef, RC_TAB[6], RC_TAB[6]);
    check("bwd_data",  data_out,       64'h0da741eb852fc963);
    check("bwd_round", 64'(round_out), 64'h6);

    // Constants and wrap
    beat(1'b1, 64'h0, 64'h0, RC_TAB[1]);
    check("const_r1_data", data_out, 64'h13198a2e03707344);
    for (int r = 2; r <= 10; r++) beat(1'b0, 64'h0, 64'h0, RC_TAB[r]);
    check("const_r10_last",  64'(out_last),  64'h1);
    check("const_r10_round", 64'(round_out), 64'ha);
    beat(1'b0, 64'h0, 64'h0, RC_TAB[1]);
    check("wrap_round", 64'(round_out), 64'h1);
    check("wrap_data",  data_out,       64'h13198a2e03707344);
    check("wrap_last",  64'(out_last),  64'h0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_first = 1'b0;
    data_in = 64'hdeadbeefcafef00d; key_in = 64'h0f1e2d3c4b5a6978; rc_in = RC_TAB[2];
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_in_ready", 64'(in_ready),  64'h0);
      check("stall_data",     data_out,       64'h13198a2e03707344);
      check("stall_round",    64'(round_out), 64'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("resume_round", 64'(round_out), 64'h2);
    check("resume_valid", 64'(out_valid), 64'h1);
    beat(1'b0, 64'h0, 64'h0, RC_TAB[3]);
    check("resume_next_round", 64'(round_out), 64'h3);
    check("resume_next_data",  data_out, 64'h082efa98ec4e6c89);

    // Restart with in_first where round 7 would be next
    for (int r = 4; r <= 6; r++) beat(1'b0, 64'h0, 64'h0, RC_TAB[r]);
    beat(1'b1, 64'h0, 64'h0, RC_TAB[1]);
    check("restart_round", 64'(round_out), 64'h1);
    check("restart_data",  data_out,       64'h13198a2e03707344);

    // Asynchronous reset mid-stream
    beat(1'b0, 64'h0123456789abcdef, 64'h0, RC_TAB[2]);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'h0);
    check("async_rst_data",  data_out,       64'h0);
    check("async_rst_round", 64'(round_out), 64'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

`ifndef PRINCE_RC_ROM_EN
    beat(1'b1, 64'h0, 64'h0, 64'hffffffffffffffff);
    check("ext_rc_data",  data_out,       64'hffffffffffffffff);
    check("ext_rc_round", 64'(round_out), 64'h1);
`else
    beat(1'b1, 64'h0, 64'h0, 64'h0);
    check("rom_rc_data", data_out, 64'h13198a2e03707344);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prince_sr_rcadd.md
# prince_sr_rcadd

Round-based PRINCE datapath stage that registers the state and applies ShiftRows plus round-constant and key addition. It sits next to the M' linear layer:
- **Forward rounds 1–5:** it consumes M' output and applies SR, then adds RC and k1.
- **Backward rounds 6–10:** it adds k1 and RC, then applies SR⁻¹, producing the value that feeds M'.

It holds a round counter and a single-entry valid/ready output register.

## Interface
- `RC_WIDTH`, default 64, round-constant width; fixed at 64.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  stage can accept a beat
- `in_first`  in  1  beat is round 1 of a new block; restarts the round counter
- `data_in`  in  64  state; nibble 0 = `[63:60]`, nibble 15 = `[3:0]`
- `key_in`  in  64  k1, sampled with each accepted beat
- `rc_in`  in  64  external round constant; present only without `PRINCE_RC_ROM_EN`
- `out_valid`  out  1  `data_out` holds a result
- `out_ready`  in  1  downstream accepts
- `data_out`  out  64  registered result
- `round_out`  out  4  round index (1..10) of the held result
- `out_last`  out  1  held result is round 10

## Operation
- **Round counter `r`, 4-bit, range 1..10.**
  - An accepted beat uses `r_use = 1` if `in_first`, else the stored `r`.
  - After the beat, `r` becomes `r_use + 1`, wrapping from 10 to 1.
- **Function for rounds 1–5:** `data_out = SR(data_in) ^ RC[r_use] ^ key_in`.
- **Function for rounds 6–10:** `data_out = SR⁻¹(data_in ^ RC[r_use] ^ key_in)`.
- **SR:** output nibble i = input nibble `{0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11}[i]`.
- **SR⁻¹:** output nibble i = input nibble `{0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3}[i]`.
- **RC ROM (PRINCE RC1..RC10):**
  - RC1 = 13198a2e03707344
  - RC2 = a4093822299f31d0
  - RC3 = 082efa98ec4e6c89
  - RC4 = 452821e638d01377
  - RC5 = be5466cf34e90c6c
  - RC6 = 7ef84f78fd955cb1
  - RC7 = 85840851f1ac43aa
  - RC8 = c882d32f25323c54
  - RC9 = 64a51195e0e3610d
  - RC10 = d3b5a399ca0c2399
- **Handshake:**
  - `in_ready = !out_valid || out_ready`.
  - Accept when `in_valid && in_ready`.
  - The output register loads on accept.
  - `out_valid` clears when the output is consumed (`out_valid && out_ready`) and no new beat is accepted in that cycle.
- **Simultaneous consume and accept:** the register reloads and `out_valid` stays 1; full throughput of 1 beat/cycle.
- **Stall:** while `out_valid && !out_ready`, `data_out`, `round_out` and `out_last` are held stable and `in_ready = 0`.
- **Round-boundary sequencing:** the 5→6 transition needs no special handling; the function is selected purely by `r_use`.
- **`in_first` mid-block:** the counter restarts at 1 and the partial block is abandoned without error.
- **Reset values:**
  - `out_valid = 0`, `data_out = 0`, `round_out = 1`, `out_last = 0`, `r = 1`.
  - `in_ready = 1` after reset.
  - Reset mid-block discards the held result and the round state.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `data_out` with `out_valid = 1` after edge N.
- `in_ready` is combinational from `out_valid` and `out_ready`; there is no combinational path from `data_in` to `data_out`.
- Reset asserts asynchronously and is released synchronously by the surrounding design.

## Configuration
- `PRINCE_RC_ROM_EN`:
  - **Defined:** RC comes from the internal 10-entry ROM indexed by `r_use`, and the `rc_in` port is absent.
  - **Undefined:** `rc_in` is present and replaces `RC[r_use]` in both formulas. The round counter, `round_out` and `out_last` still operate identically.

## Test plan
- **Forward SR:** reset, then `in_first = 1`, `data_in = 0123456789abcdef`, `key_in = RC1` → after 1 cycle, `data_out = 05af49e38d27c16b`, `round_out = 1`, `out_valid = 1`.
- **Backward SR⁻¹:** stream 5 zero beats, then a sixth beat with `data_in = 0123456789abcdef`, `key_in = RC6` → `data_out = 0da741eb852fc963`, `round_out = 6`.
- **Constant and wrap check:**
  - 10 consecutive beats with `data_in = 0`, `key_in = 0`, `out_ready = 1` → round 1 gives `data_out = 13198a2e03707344`.
  - Round 10 gives `out_last = 1`.
  - The next beat without `in_first` gives `round_out = 1`.
- **Backpressure:** hold `out_ready = 0` for 3 cycles with `in_valid = 1` → `in_ready = 0`, `data_out` stable, counter not advanced. Release → one beat/cycle resumes, with no loss and no duplication.
- **Restart and reset:**
  - `in_first` asserted at round 7 → result is tagged `round_out = 1` and uses RC1.
  - Asserting `rst` mid-stream → `out_valid = 0` and `data_out = 0` immediately, without waiting for a clock.
- **Build without `PRINCE_RC_ROM_EN`:** `rc_in = ffffffffffffffff`, `data_in = 0`, `key_in = 0`, round 1 → `data_out = ffffffffffffffff`.
